// File: rtl/tlc_phase_sched.sv
// Two-road intersection phase scheduler: detector arbitration, green/yellow/all-red
// sequencing, flash mode and test-speed mode. Define TLC_PED_EN to add the walk phase.
module tlc_phase_sched #(
    parameter int TW        = 6,
    parameter int TICK_DIV  = 4,
    parameter int GREEN_MIN = 10,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 8
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       TEST,
    input  logic       FM,
    input  logic       REQ1,
    input  logic       REQ2,
`ifdef TLC_PED_EN
    input  logic       PED,
    output logic       WALK,
`endif
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic       ACK1,
    output logic       ACK2,
    output logic [2:0] PHASE
);

    typedef enum logic [2:0] {
        S_AR2   = 3'd0,
        S_G1    = 3'd1,
        S_Y1    = 3'd2,
        S_AR1   = 3'd3,
        S_G2    = 3'd4,
        S_Y2    = 3'd5,
        S_FLASH = 3'd6,
        S_WALK  = 3'd7
    } state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = TW + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] G_MIN_E  = EW'(GREEN_MIN);
    localparam logic [EW-1:0] G_MAX_E  = EW'(GREEN_MAX);
    localparam logic [TW-1:0] G_MAX_T  = TW'(GREEN_MAX);

    // Timer reload for a phase being entered; green and flash phases do not use it.
    function automatic logic [TW-1:0] phase_load(input state_e s);
        logic [TW-1:0] v;
        case (s)
            S_Y1, S_Y2:   v = TW'(YELLOW_T - 1);
            S_AR1, S_AR2: v = TW'(ALLRED_T - 1);
            S_WALK:       v = TW'(WALK_T - 1);
            default:      v = {TW{1'b0}};
        endcase
        return v;
    endfunction

    function automatic logic [TW-1:0] sat_elapsed(input logic [EW-1:0] e);
        return (e >= G_MAX_E) ? G_MAX_T : e[TW-1:0];
    endfunction

    // Green yields only when the other road waits, minimum is served and own demand is gone or capped.
    function automatic logic green_done(input logic pend_other, input logic req_own,
                                        input logic [EW-1:0] e);
        return pend_other && (e >= G_MIN_E) && (!req_own || (e >= G_MAX_E));
    endfunction

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] elapsed_q, elapsed_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          pend1_q, pend1_d;
    logic          pend2_q, pend2_d;
    logic          flash_q, flash_d;
    logic          ack1_q, ack2_q;
    logic          tick_s;
    logic          enter_g1_s, enter_g2_s;
    logic [EW-1:0] e_s;
    logic [5:0]    lamps_s;
    logic          pedp_s;

    // Tick prescaler; test mode ticks every cycle and parks the count at zero.
    always_comb begin
        tick_s = TEST | (presc_q == PRE_LAST);
        if (TEST) begin
            presc_d = {PW{1'b0}};
        end else if (presc_q == PRE_LAST) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Next-state, timer, elapsed and flash-bit logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        elapsed_d = elapsed_q;
        flash_d   = flash_q;
        e_s       = {1'b0, elapsed_q} + EW'(1);
        if (tick_s) begin
            case (state_q)
                S_G1: begin
                    elapsed_d = sat_elapsed(e_s);
                    if (green_done(pend2_q, REQ1, e_s)) begin
                        state_d = S_Y1;
                    end else begin
                        state_d = S_G1;
                    end
                end
                S_G2: begin
                    elapsed_d = sat_elapsed(e_s);
                    if (green_done(pend1_q, REQ2, e_s)) begin
                        state_d = S_Y2;
                    end else begin
                        state_d = S_G2;
                    end
                end
                S_Y1, S_Y2, S_WALK: begin
                    if (timer_q == {TW{1'b0}}) begin
                        if (state_q == S_Y1) begin
                            state_d = S_AR1;
                        end else if (state_q == S_Y2) begin
                            state_d = S_AR2;
                        end else begin
                            state_d = S_G1;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_AR1: begin
                    if (timer_q == {TW{1'b0}}) begin
                        state_d = FM ? S_FLASH : S_G2;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_AR2: begin
                    if (timer_q == {TW{1'b0}}) begin
                        if (FM) begin
                            state_d = S_FLASH;
                        end else if (pedp_s) begin
                            state_d = S_WALK;
                        end else begin
                            state_d = S_G1;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_FLASH: begin
                    if (!FM) begin
                        state_d = S_AR2;
                    end else begin
                        flash_d = ~flash_q;
                    end
                end
                default: begin
                    state_d = S_AR2;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Any phase change reloads the timer and clears green age and flash bit.
        if (state_d != state_q) begin
            timer_d   = phase_load(state_d);
            elapsed_d = {TW{1'b0}};
            flash_d   = 1'b0;
        end else begin
            flash_d   = flash_d;
        end
    end

    // Request latches: a green entry clears its own latch and beats a same-cycle request.
    always_comb begin
        enter_g1_s = (state_d == S_G1) && (state_q != S_G1);
        enter_g2_s = (state_d == S_G2) && (state_q != S_G2);
        pend1_d    = enter_g1_s ? 1'b0 : (pend1_q | REQ1);
        pend2_d    = enter_g2_s ? 1'b0 : (pend2_q | REQ2);
    end

    // Sequencer registers with synchronous clear.
    always_ff @(posedge CK) begin
        if (CLR) begin
            state_q   <= S_AR2;
            timer_q   <= phase_load(S_AR2);
            elapsed_q <= {TW{1'b0}};
            presc_q   <= {PW{1'b0}};
            pend1_q   <= 1'b0;
            pend2_q   <= 1'b0;
            flash_q   <= 1'b0;
            ack1_q    <= 1'b0;
            ack2_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            presc_q   <= presc_d;
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            flash_q   <= flash_d;
            ack1_q    <= enter_g1_s;
            ack2_q    <= enter_g2_s;
        end
    end

`ifdef TLC_PED_EN
    logic pedp_q, pedp_d;

    // Pedestrian latch, cleared as the walk phase is entered.
    always_comb begin
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            pedp_d = 1'b0;
        end else begin
            pedp_d = pedp_q | PED;
        end
        pedp_s = pedp_q;
    end

    // Pedestrian latch register.
    always_ff @(posedge CK) begin
        if (CLR) begin
            pedp_q <= 1'b0;
        end else begin
            pedp_q <= pedp_d;
        end
    end

    assign WALK = (state_q == S_WALK);
`else
    assign pedp_s = 1'b0;
`endif

    // Moore lamp decode, bit order {GRN1,YLW1,RED1,GRN2,YLW2,RED2}.
    always_comb begin
        lamps_s = 6'b001_001;
        case (state_q)
            S_G1:    lamps_s = 6'b100_001;
            S_Y1:    lamps_s = 6'b010_001;
            S_G2:    lamps_s = 6'b001_100;
            S_Y2:    lamps_s = 6'b001_010;
            S_FLASH: lamps_s = {1'b0, flash_q, 1'b0, 1'b0, 1'b0, flash_q};
            default: lamps_s = 6'b001_001;
        endcase
    end

    assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = lamps_s;
    assign ACK1  = ack1_q;
    assign ACK2  = ack2_q;
    assign PHASE = state_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Scoreboard bench for tlc_phase_sched: a phase-level reference model queues the expected
// outputs every clock, a monitor compares them; directed phase-length checks plus random traffic.
module tb_tlc_phase_sched;

    localparam int TW = 6, TICK_DIV = 4, GREEN_MIN = 10, GREEN_MAX = 30;
    localparam int YELLOW_T = 4, ALLRED_T = 2, WALK_T = 8;
    localparam int P_AR2 = 0, P_G1 = 1, P_Y1 = 2, P_AR1 = 3, P_G2 = 4, P_Y2 = 5, P_FLASH = 6, P_WALK = 7;
`ifdef TLC_PED_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic CK = 1'b0, CLR = 1'b1, TEST = 1'b0, FM = 1'b0, REQ1 = 1'b0, REQ2 = 1'b0, ped_in = 1'b0;
    logic GRN1, YLW1, RED1, GRN2, YLW2, RED2, ACK1, ACK2;
    logic [2:0] PHASE;
`ifdef TLC_PED_EN
    logic WALK;
`endif

    int errors = 0, checks = 0;

    typedef struct packed {
        logic [2:0] ph;
        logic [5:0] lamps;
        logic       a1;
        logic       a2;
        logic       wk;
    } exp_t;
    exp_t sb[$];

    tlc_phase_sched #(.TW(TW), .TICK_DIV(TICK_DIV), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
                      .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)) dut (
        .CK(CK), .CLR(CLR), .TEST(TEST), .FM(FM), .REQ1(REQ1), .REQ2(REQ2),
`ifdef TLC_PED_EN
        .PED(ped_in), .WALK(WALK),
`endif
        .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1), .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
        .ACK1(ACK1), .ACK2(ACK2), .PHASE(PHASE)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (phase-level, remaining-ticks view) ----------------
    int m_ph, m_rem, m_served, m_pre;
    bit m_p1, m_p2, m_pp, m_fl, m_a1, m_a2;

    function automatic int dur_of(input int ph);
        if (ph == P_Y1 || ph == P_Y2) return YELLOW_T;
        if (ph == P_AR1 || ph == P_AR2) return ALLRED_T;
        if (ph == P_WALK) return WALK_T;
        return 0;
    endfunction

    function automatic int exit_of(input int ph, input bit fm, input bit pp);
        if (ph == P_Y1) return P_AR1;
        if (ph == P_Y2) return P_AR2;
        if (ph == P_WALK) return P_G1;
        if (ph == P_AR1) return fm ? P_FLASH : P_G2;
        if (fm) return P_FLASH;
        return (PED_ON && pp) ? P_WALK : P_G1;
    endfunction

    function automatic logic [5:0] lamps_of(input int ph, input bit fl);
        logic [2:0] r1, r2;
        if (ph == P_FLASH) return {1'b0, fl, 1'b0, 3'b000} | {5'b00000, fl};
        r1 = (ph == P_G1) ? 3'b100 : (ph == P_Y1) ? 3'b010 : 3'b001;
        r2 = (ph == P_G2) ? 3'b100 : (ph == P_Y2) ? 3'b010 : 3'b001;
        return {r1, r2};
    endfunction

    task automatic model_step();
        int nph;
        bit tick;
        exp_t e;
        if (CLR) begin
            m_ph = P_AR2; m_rem = ALLRED_T; m_served = 0; m_pre = 0;
            m_p1 = 0; m_p2 = 0; m_pp = 0; m_fl = 0; m_a1 = 0; m_a2 = 0;
        end else begin
            tick  = TEST || (m_pre == TICK_DIV - 1);
            m_pre = TEST ? 0 : (m_pre + 1) % TICK_DIV;
            nph   = m_ph;
            if (tick) begin
                if (m_ph == P_G1) begin
                    m_served++;
                    if (m_p2 && m_served >= GREEN_MIN && (!REQ1 || m_served >= GREEN_MAX)) nph = P_Y1;
                end else if (m_ph == P_G2) begin
                    m_served++;
                    if (m_p1 && m_served >= GREEN_MIN && (!REQ2 || m_served >= GREEN_MAX)) nph = P_Y2;
                end else if (m_ph == P_FLASH) begin
                    if (!FM) nph = P_AR2;
                    else m_fl = !m_fl;
                end else begin
                    m_rem--;
                    if (m_rem == 0) nph = exit_of(m_ph, FM, m_pp);
                end
            end
            m_a1 = (nph == P_G1) && (m_ph != P_G1);
            m_a2 = (nph == P_G2) && (m_ph != P_G2);
            m_p1 = m_a1 ? 1'b0 : (m_p1 | REQ1);
            m_p2 = m_a2 ? 1'b0 : (m_p2 | REQ2);
            m_pp = (nph == P_WALK && m_ph != P_WALK) ? 1'b0 : (m_pp | ped_in);
            if (nph != m_ph) begin
                m_rem = dur_of(nph); m_served = 0; m_fl = 0;
            end
            m_ph = nph;
        end
        e.ph = 3'(m_ph); e.lamps = lamps_of(m_ph, m_fl);
        e.a1 = m_a1; e.a2 = m_a2; e.wk = (m_ph == P_WALK);
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge CK);
        model_step();
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("phase", int'(PHASE), int'(e.ph));
                chk("lamps", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), int'(e.lamps));
                chk("ack1", int'(ACK1), int'(e.a1));
                chk("ack2", int'(ACK2), int'(e.a2));
`ifdef TLC_PED_EN
                chk("walk", int'(WALK), int'(e.wk));
`endif
                if (PHASE != 3'd6) begin
                    chk("one_lamp_road1", int'(GRN1) + int'(YLW1) + int'(RED1), 1);
                    chk("one_lamp_road2", int'(GRN2) + int'(YLW2) + int'(RED2), 1);
                    chk("never_both_go", int'(!RED1 && !RED2), 0);
                end
            end
        end
    end

    // Counts negedges spent in phase p, returning at the first negedge outside it.
    task automatic run_phase(input int p, output int n);
        n = 0;
        while (int'(PHASE) == p && n < 500) begin
            n++;
            @(negedge CK);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int n, acks;
        CLR = 1'b1;
        repeat (2) @(negedge CK);
        CLR = 1'b0; TEST = 1'b1;

        // 1: rest in G1 with one ACK1
        run_phase(P_AR2, n); chk("t1_ar2_len", n, ALLRED_T);
        chk("t1_enter_g1", int'(PHASE), P_G1);
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            acks += int'(ACK1);
            @(negedge CK);
        end
        chk("t1_ack1_count", acks, 1);
        chk("t1_rest_g1", int'(PHASE), P_G1);

        // 2: REQ2 pulse at G1 cycle 3
        CLR = 1'b1; repeat (2) @(negedge CK); CLR = 1'b0;
        run_phase(P_AR2, n); chk("t2_ar2_len", n, ALLRED_T);
        n = 0;
        while (int'(PHASE) == P_G1 && n < 500) begin
            REQ2 = (n == 3); n++; @(negedge CK);
        end
        REQ2 = 1'b0;
        chk("t2_g1_len", n, GREEN_MIN);
        run_phase(P_Y1, n);  chk("t2_y1_len", n, YELLOW_T);
        run_phase(P_AR1, n); chk("t2_ar1_len", n, ALLRED_T);
        chk("t2_enter_g2", int'(PHASE), P_G2);
        chk("t2_ack2", int'(ACK2), 1);

        // 3: REQ1 held keeps G1 to its maximum; dropping REQ1 ends it early
        REQ1 = 1'b1;
        run_phase(P_G2, n);  chk("t3_g2_len", n, GREEN_MIN);
        run_phase(P_Y2, n);  chk("t3_y2_len", n, YELLOW_T);
        run_phase(P_AR2, n); chk("t3_ar2_len", n, ALLRED_T);
        n = 0;
        while (int'(PHASE) == P_G1 && n < 500) begin
            REQ2 = (n == 1); n++; @(negedge CK);
        end
        chk("t3_g1_max", n, GREEN_MAX);
        run_phase(P_Y1, n);  run_phase(P_AR1, n);
        run_phase(P_G2, n);  chk("t3_g2_len_b", n, GREEN_MIN);
        run_phase(P_Y2, n);  run_phase(P_AR2, n);
        n = 0;
        while (int'(PHASE) == P_G1 && n < 500) begin
            REQ2 = (n == 1); REQ1 = (n < 15); n++; @(negedge CK);
        end
        REQ1 = 1'b0; REQ2 = 1'b0;
        chk("t3_g1_early_exit", n, 16);

        // 4: prescaled yellow and all-red
        TEST = 1'b0;
        run_phase(P_Y1, n);  chk("t4_y1_len", n, YELLOW_T * TICK_DIV);
        run_phase(P_AR1, n); chk("t4_ar1_len", n, ALLRED_T * TICK_DIV);
        chk("t4_enter_g2", int'(PHASE), P_G2);

        // 5: flash requested during G2 with REQ1 pending
        TEST = 1'b1; FM = 1'b1;
        run_phase(P_G2, n);  chk("t5_g2_len", n, GREEN_MIN);
        run_phase(P_Y2, n);  chk("t5_y2_len", n, YELLOW_T);
        run_phase(P_AR2, n); chk("t5_ar2_len", n, ALLRED_T);
        chk("t5_flash", int'(PHASE), P_FLASH);
        for (int k = 0; k < 6; k++) begin
            chk("t5_ylw1_toggle", int'(YLW1), k % 2);
            chk("t5_red2_toggle", int'(RED2), k % 2);
            chk("t5_no_green", int'(GRN1 | GRN2), 0);
            @(negedge CK);
        end
        FM = 1'b0;
        @(negedge CK);
        run_phase(P_AR2, n); chk("t5_ar2_after_flash", n, ALLRED_T);
        chk("t5_back_g1", int'(PHASE), P_G1);

        // 6: reset mid-Y1 with pend1 set clears the latches
        n = 0;
        while (int'(PHASE) == P_G1 && n < 500) begin
            REQ2 = (n == 0); n++; @(negedge CK);
        end
        REQ2 = 1'b0;
        chk("t6_g1_len", n, GREEN_MIN);
        REQ1 = 1'b1; @(negedge CK); REQ1 = 1'b0;
        CLR = 1'b1; @(negedge CK); CLR = 1'b0;
        chk("t6_phase_reset", int'(PHASE), P_AR2);
        chk("t6_lamps_reset", int'({GRN1, YLW1, RED1, GRN2, YLW2, RED2}), 9);
        run_phase(P_AR2, n); chk("t6_ar2_len", n, ALLRED_T);
        chk("t6_ack1", int'(ACK1), 1);
        repeat (60) @(negedge CK);
        chk("t6_pend2_cleared", int'(PHASE), P_G1);

`ifdef TLC_PED_EN
        REQ2 = 1'b1; @(negedge CK); REQ2 = 1'b0;
        run_phase(P_G1, n); run_phase(P_Y1, n); run_phase(P_AR1, n);
        ped_in = 1'b1; REQ1 = 1'b1; @(negedge CK); ped_in = 1'b0; REQ1 = 1'b0;
        run_phase(P_G2, n); run_phase(P_Y2, n); run_phase(P_AR2, n);
        chk("ped_walk_lamp", int'(WALK), 1);
        run_phase(P_WALK, n); chk("ped_walk_len", n, WALK_T);
        chk("ped_then_g1", int'(PHASE), P_G1);
`endif

        // random traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) TEST = ~TEST;
            if ($urandom_range(0, 149) == 0) FM = ~FM;
            REQ1   = ($urandom_range(0, 15) < 3);
            REQ2   = ($urandom_range(0, 15) < 3);
            ped_in = ($urandom_range(0, 39) == 0);
            CLR    = ($urandom_range(0, 699) == 0);
            @(negedge CK);
        end
        CLR = 1'b0;
        @(negedge CK);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlc_phase_sched.md
Name: tlc_phase_sched

Overview:
Phase scheduler for a two-road signalised intersection (road 1 main, road 2 cross). It arbitrates green time between vehicle-detector requests on both roads and sequences green, yellow and all-red phases with a prescaled timer. It adds flash mode and a test-speed mode. It drives the GRN/YLW/RED lamp outputs of both roads directly from registered state.

Parameters:
TW, 6, width of timer and elapsed counters
TICK_DIV, 4, clock cycles per timer tick (>=1)
GREEN_MIN, 10, minimum green in ticks
GREEN_MAX, 30, maximum green in ticks when the own road keeps requesting
YELLOW_T, 4, yellow duration in ticks
ALLRED_T, 2, all-red duration in ticks
WALK_T, 8, walk duration in ticks (used only with PED_EN)

Ports:
CK  in  1  clock; all flops rising-edge
CLR  in  1  reset, synchronous, active-high
TEST  in  1  1 = tick every cycle (prescaler bypassed)
FM  in  1  flash-mode request, level
REQ1  in  1  road-1 vehicle detector, level
REQ2  in  1  road-2 vehicle detector, level
GRN1/YLW1/RED1  out  1 each  road-1 lamps
GRN2/YLW2/RED2  out  1 each  road-2 lamps
ACK1  out  1  one-cycle pulse on entry to G1
ACK2  out  1  one-cycle pulse on entry to G2
PHASE  out  3  state code: AR2=0 G1=1 Y1=2 AR1=3 G2=4 Y2=5 FLASH=6 WALK=7

Behaviour:
- Clocking and reset: one clock CK; reset CLR is synchronous and active-high and overrides everything. On reset: state=AR2, timer=ALLRED_T-1, prescaler=0, elapsed=0, pend1=pend2=0, flash bit=0, ACK=0.
- Reset output values: RED1=RED2=1, all other lamps 0, PHASE=0.
- Tick generation: the prescaler counts 0..TICK_DIV-1 and tick=1 when count==TICK_DIV-1. TEST=1 forces tick=1 every cycle and holds the prescaler at 0.
- Fixed-length phases (Y1, Y2, AR1, AR2, WALK):
  - On entry, timer loads duration-1.
  - Each tick decrements the timer.
  - A tick with timer==0 leaves the phase, so each phase lasts exactly its duration in ticks.
- Transitions:
  - Y1->AR1, AR1->G2, Y2->AR2, AR2->G1.
  - At the end of AR1 or AR2, FM=1 goes to FLASH instead. FM has priority over green.
- Green phases (G1 shown; G2 is symmetric):
  - elapsed clears on entry.
  - Each tick: e=elapsed+1, and elapsed=min(e,GREEN_MAX).
  - Leave for Y1 on a tick when pend2 && e>=GREEN_MIN && (!REQ1 || e>=GREEN_MAX).
  - With pend2=0 the phase rests in G1 indefinitely.
  - FM does not cut green short.
- Request latches:
  - pend2 sets on any cycle with REQ2=1.
  - pend2 clears on the cycle G2 is entered; clear wins over a simultaneous set.
  - ACK2 pulses on that same cycle. pend1/ACK1 are symmetric.
- FLASH:
  - GRN*=YLW2=RED1=0; YLW1=RED2=flash bit.
  - The flash bit toggles each tick.
  - FM sampled 0 on a tick moves to AR2 with timer=ALLRED_T-1 and flash bit cleared.
- Lamp decode, Moore from the state register with no extra latency:
  - G1: GRN1, RED2
  - Y1: YLW1, RED2
  - AR1/AR2/WALK: RED1, RED2
  - G2: RED1, GRN2
  - Y2: RED1, YLW2
- Invariant: never both roads non-red outside FLASH. Exactly one lamp per road is lit except in FLASH.
- Counter widths: TW must hold GREEN_MAX and every duration-1; the counters never wrap.

Optional Feature:
Macro TLC_PED_EN.
- Defined:
  - Adds input PED (level) and output WALK (1 bit).
  - pedp latches on PED=1 and clears on WALK entry.
  - At the end of AR2 with FM=0 and pedp=1, go to WALK for WALK_T ticks, then G1. WALK=1 only in the WALK state.
  - FM is still checked first.
- Not defined: the PED and WALK ports are absent; AR2 goes directly to G1 or FLASH; PHASE never equals 7.

Test Plan:
1. CLR=1 for 2 cycles, then TEST=1 with no requests -> AR2 for 2 cycles, then G1 (GRN1=RED2=1); stays in G1 for 100 cycles; ACK1 pulses once.
2. TEST=1, in G1; one-cycle REQ2 at G1 cycle 3 -> G1 lasts 10 cycles, Y1 4, AR1 2; G2 entered with an ACK2 pulse 16 cycles after G1 entry.
3. TEST=1, REQ1 held high and REQ2 pulsed early -> G1 lasts 30 cycles; if REQ1 drops at cycle 15, the exit is at the cycle-15 tick.
4. TEST=0, TICK_DIV=4, in Y1 -> Y1 lasts 16 cycles and AR1 lasts 8 cycles.
5. TEST=1, FM=1 asserted in G2 with REQ1 pending -> Y2 (4 cycles), AR2 (2 cycles), then FLASH with YLW1/RED2 toggling every cycle and GRN1=GRN2=0. Drop FM -> AR2 for 2 cycles, then G1.
6. CLR pulsed for 1 cycle mid-Y1 with pend1 set -> next cycle: PHASE=0, RED1=RED2=1, pending latches cleared. With TLC_PED_EN, PED pulsed during G2 -> WALK=1 for 8 cycles between AR2 and G1.
